// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_skid_stage pipeline register: occupancy
// encoding, bubble fill value and stats counter width.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    // Bubble payload is all-zero: we=0 and aluop=NOP in the core's encoding.
    localparam logic BUBBLE_BIT = 1'b0;

    localparam int STATS_W = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module pipe_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with a 2-entry skid buffer and a scratch word
// returned to the producer. Optional stats ports under PIPE_SKID_STATS_EN.
//
// Handshake: a word moves when valid and ready are both high at a rising edge;
// valid never depends on ready, and up_ready is a register (no dn_ready->up_ready path).
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 107,
    parameter int                SCRATCH_W = 66,
    parameter logic [DATA_W-1:0] BUBBLE    = {DATA_W{BUBBLE_BIT}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic [DATA_W-1:0]    up_data,
    input  logic                 up_hold,
    input  logic [SCRATCH_W-1:0] up_scratch,
    output logic [SCRATCH_W-1:0] scratch_o,
    output logic                 dn_valid,
    input  logic                 dn_ready,
    output logic [DATA_W-1:0]    dn_data,
    output logic [1:0]           occupancy
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [STATS_W-1:0]   stall_cnt,
    output logic [STATS_W-1:0]   bubble_cnt
`endif
);

    occ_t                 r_occ;
    logic [DATA_W-1:0]    r_main;
    logic [DATA_W-1:0]    r_skid;
    logic                 r_up_ready;
    logic [SCRATCH_W-1:0] r_scratch;

    occ_t                 w_occ_nxt;
    logic [DATA_W-1:0]    w_main_nxt;
    logic [DATA_W-1:0]    w_skid_nxt;
    logic [SCRATCH_W-1:0] w_scratch_nxt;
    logic                 w_dn_valid;
    logic                 w_acc_up;
    logic                 w_acc_dn;

    assign w_dn_valid = (r_occ != OCC_EMPTY);
    assign w_acc_up   = up_valid & r_up_ready;
    assign w_acc_dn   = w_dn_valid & dn_ready;

    always_comb begin
        w_occ_nxt  = r_occ;
        w_main_nxt = r_main;
        w_skid_nxt = r_skid;
        case (r_occ)
            OCC_EMPTY: begin
                if (w_acc_up) begin
                    w_occ_nxt  = OCC_ONE;
                    w_main_nxt = up_data;
                end
            end
            OCC_ONE: begin
                if (w_acc_up && w_acc_dn) begin
                    w_main_nxt = up_data;
                end else if (w_acc_up) begin
                    w_occ_nxt  = OCC_FULL;
                    w_skid_nxt = up_data;
                end else if (w_acc_dn) begin
                    w_occ_nxt  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (w_acc_dn) begin
                    w_occ_nxt  = OCC_ONE;
                    w_main_nxt = r_skid;
                    w_skid_nxt = BUBBLE;
                end
            end
            default: begin
                w_occ_nxt  = OCC_EMPTY;
                w_skid_nxt = BUBBLE;
            end
        endcase
        // Flush kills everything held; a same-cycle offer or consume is void.
        if (flush) begin
            w_occ_nxt  = OCC_EMPTY;
            w_skid_nxt = BUBBLE;
        end
    end

    always_comb begin
        w_scratch_nxt = r_scratch;
        if (flush) begin
            w_scratch_nxt = '0;
        end else if (up_hold) begin
            w_scratch_nxt = up_scratch;
        end else if (w_acc_up) begin
            w_scratch_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ      <= OCC_EMPTY;
            r_main     <= BUBBLE;
            r_skid     <= BUBBLE;
            r_up_ready <= 1'b1;
            r_scratch  <= '0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_up_ready <= (w_occ_nxt != OCC_FULL);
            r_scratch  <= w_scratch_nxt;
        end
    end

    assign up_ready  = r_up_ready;
    assign dn_valid  = w_dn_valid;
    assign dn_data   = w_dn_valid ? r_main : BUBBLE;
    assign scratch_o = r_scratch;
    assign occupancy = r_occ;

`ifdef PIPE_SKID_STATS_EN
    logic w_stall_inc;
    logic w_bubble_inc;

    assign w_stall_inc  = up_valid & ~r_up_ready;
    assign w_bubble_inc = ~w_dn_valid & dn_ready;

    pipe_sat_counter #(.WIDTH(STATS_W)) u_stall_cnt (
        .clk     (clk),
        .i_clr   (rst),
        .i_inc   (w_stall_inc),
        .o_count (stall_cnt)
    );

    pipe_sat_counter #(.WIDTH(STATS_W)) u_bubble_cnt (
        .clk     (clk),
        .i_clr   (rst),
        .i_inc   (w_bubble_inc),
        .o_count (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: a 2-deep FIFO queue model plus
// scratch/stats model, directed scenarios and a randomized run.
module tb_pipe_skid_stage;

    localparam int DATA_W    = 107;
    localparam int SCRATCH_W = 66;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 up_valid;
    logic                 up_ready;
    logic [DATA_W-1:0]    up_data;
    logic                 up_hold;
    logic [SCRATCH_W-1:0] up_scratch;
    logic [SCRATCH_W-1:0] scratch_o;
    logic                 dn_valid;
    logic                 dn_ready;
    logic [DATA_W-1:0]    dn_data;
    logic [1:0]           occupancy;
`ifdef PIPE_SKID_STATS_EN
    logic [15:0]          stall_cnt;
    logic [15:0]          bubble_cnt;
`endif

    pipe_skid_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_hold    (up_hold),
        .up_scratch (up_scratch),
        .scratch_o  (scratch_o),
        .dn_valid   (dn_valid),
        .dn_ready   (dn_ready),
        .dn_data    (dn_data),
        .occupancy  (occupancy)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: exp_q is the in-order content of the stage (head = on dn_data).
    logic [DATA_W-1:0]    exp_q[$];
    logic [DATA_W-1:0]    seen_q[$];
    logic [SCRATCH_W-1:0] m_scratch;
    int                   m_stall;
    int                   m_bubble;

    function automatic logic [DATA_W-1:0] rand_data();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] exp_dn_data();
        return (exp_q.size() > 0) ? exp_q[0] : '0;
    endfunction

    // One clock edge: advance the model from pre-edge inputs, then settle.
    task automatic tick(output bit acc_up);
        bit a_up;
        bit a_dn;
        @(posedge clk);
        a_up = up_valid && (exp_q.size() < 2);
        a_dn = (exp_q.size() > 0) && dn_ready;
        if (rst) begin
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (up_valid && exp_q.size() >= 2 && m_stall < 65535) m_stall++;
            if (exp_q.size() == 0 && dn_ready && m_bubble < 65535) m_bubble++;
        end
        if (rst || flush) begin
            exp_q.delete();
            m_scratch = '0;
        end else begin
            if (a_dn) seen_q.push_back(dn_data);
            if (a_dn) void'(exp_q.pop_front());
            if (a_up) exp_q.push_back(up_data);
            if (up_hold) m_scratch = up_scratch;
            else if (a_up) m_scratch = '0;
        end
        #1;
        acc_up = a_up && !rst && !flush;
    endtask

    task automatic test_reset();
        bit acc;
        rst = 1'b1; flush = 1'b0; up_valid = 1'b0; up_hold = 1'b0;
        dn_ready = 1'b0; up_data = '0; up_scratch = '0;
        tick(acc);
        tick(acc);
        n_cmp++; if (dn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dn_valid: got %b expected 0", dn_valid); end
        n_cmp++; if (dn_data !== '0) begin n_fail++; $display("FAIL reset_dn_data: got %h expected 0", dn_data); end
        n_cmp++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL reset_up_ready: got %b expected 1", up_ready); end
        n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        n_cmp++; if (scratch_o !== '0) begin n_fail++; $display("FAIL reset_scratch: got %h expected 0", scratch_o); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] w[3];
        bit acc;
        for (int i = 0; i < 3; i++) w[i] = rand_data();
        dn_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up_valid = 1'b1;
            up_data  = w[i];
            tick(acc);
            n_cmp++; if (dn_valid !== 1'b1 || dn_data !== w[i]) begin n_fail++; $display("FAIL stream_data%0d: got v=%b %h expected v=1 %h", i, dn_valid, dn_data, w[i]); end
            n_cmp++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ%0d: got %0d expected 1", i, occupancy); end
        end
        up_valid = 1'b0;
        tick(acc);
        n_cmp++; if (dn_valid !== 1'b0 || dn_data !== '0) begin n_fail++; $display("FAIL stream_drain: got v=%b %h expected v=0 0", dn_valid, dn_data); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] w[3];
        bit acc;
        int idx;
        for (int i = 0; i < 3; i++) w[i] = rand_data();
        seen_q.delete();
        dn_ready = 1'b0;
        up_valid = 1'b1;
        idx      = 0;
        up_data  = w[0];
        for (int c = 0; c < 3; c++) begin
            tick(acc);
            if (acc) idx++;
            if (idx < 3) up_data = w[idx];
        end
        n_cmp++; if (idx !== 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", idx); end
        n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_occ_full: got %0d expected 2", occupancy); end
        n_cmp++; if (up_ready !== 1'b0) begin n_fail++; $display("FAIL bp_up_ready: got %b expected 0", up_ready); end
        n_cmp++; if (dn_data !== w[0]) begin n_fail++; $display("FAIL bp_head: got %h expected %h", dn_data, w[0]); end
        dn_ready = 1'b1;
        for (int c = 0; c < 12 && seen_q.size() < 3; c++) begin
            if (idx >= 3) up_valid = 1'b0;
            tick(acc);
            if (acc) idx++;
            if (idx < 3) up_data = w[idx];
        end
        up_valid = 1'b0;
        n_cmp++; if (seen_q.size() !== 3) begin n_fail++; $display("FAIL bp_count: got %0d expected 3", seen_q.size()); end
        for (int k = 0; k < 3 && k < seen_q.size(); k++) begin
            n_cmp++; if (seen_q[k] !== w[k]) begin n_fail++; $display("FAIL bp_order%0d: got %h expected %h", k, seen_q[k], w[k]); end
        end
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] w[3];
        bit acc;
        for (int i = 0; i < 3; i++) w[i] = rand_data();
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_data = w[0]; tick(acc);
        up_data = w[1]; tick(acc);
        n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_prefill: got %0d expected 2", occupancy); end
        seen_q.delete();
        flush = 1'b1; up_data = w[2]; dn_ready = 1'b1;
        tick(acc);
        flush = 1'b0; up_valid = 1'b0;
        n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ: got %0d expected 0", occupancy); end
        n_cmp++; if (dn_valid !== 1'b0 || dn_data !== '0) begin n_fail++; $display("FAIL flush_dn: got v=%b %h expected v=0 0", dn_valid, dn_data); end
        n_cmp++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL flush_up_ready: got %b expected 1", up_ready); end
        for (int c = 0; c < 3; c++) begin
            tick(acc);
            n_cmp++; if (dn_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak%0d: got v=%b data %h expected v=0", c, dn_valid, dn_data); end
        end
        // Reset with a full stage (flush also high) must discard both entries.
        dn_ready = 1'b0; up_valid = 1'b1;
        up_data = w[0]; tick(acc);
        up_data = w[1]; tick(acc);
        rst = 1'b1; flush = 1'b1; up_valid = 1'b0;
        tick(acc);
        rst = 1'b0; flush = 1'b0;
        n_cmp++; if (occupancy !== 2'd0 || dn_valid !== 1'b0 || up_ready !== 1'b1) begin n_fail++; $display("FAIL rst_full: got occ=%0d v=%b rdy=%b expected 0 0 1", occupancy, dn_valid, up_ready); end
    endtask

    task automatic test_scratch();
        logic [SCRATCH_W-1:0] k;
        bit acc;
        k = 66'h3_0000_0001_0000_0002;
        dn_ready = 1'b1; up_valid = 1'b0;
        up_hold = 1'b1; up_scratch = k;
        tick(acc);
        n_cmp++; if (scratch_o !== k) begin n_fail++; $display("FAIL scratch_capture: got %h expected %h", scratch_o, k); end
        up_hold = 1'b0; up_scratch = '0;
        tick(acc);
        n_cmp++; if (scratch_o !== k) begin n_fail++; $display("FAIL scratch_hold: got %h expected %h", scratch_o, k); end
        up_valid = 1'b1; up_data = rand_data();
        tick(acc);
        up_valid = 1'b0;
        n_cmp++; if (scratch_o !== '0) begin n_fail++; $display("FAIL scratch_clear: got %h expected 0", scratch_o); end
        // Hold together with an accepted word: data flows and scratch is captured.
        up_valid = 1'b1; up_hold = 1'b1; up_scratch = ~k; up_data = rand_data();
        tick(acc);
        up_valid = 1'b0; up_hold = 1'b0;
        n_cmp++; if (scratch_o !== ~k || dn_valid !== 1'b1) begin n_fail++; $display("FAIL scratch_hold_accept: got %h v=%b expected %h v=1", scratch_o, dn_valid, ~k); end
        tick(acc);
    endtask

    task automatic test_random();
        bit acc;
        for (int c = 0; c < 400; c++) begin
            up_valid   = ($urandom_range(0, 3) != 0);
            up_data    = rand_data();
            dn_ready   = ($urandom_range(0, 2) != 0);
            up_hold    = ($urandom_range(0, 3) == 0);
            up_scratch = {$urandom_range(0, 3), $urandom, $urandom};
            flush      = ($urandom_range(0, 15) == 0);
            tick(acc);
            n_cmp++;
            if (dn_valid !== (exp_q.size() > 0) || dn_data !== exp_dn_data() ||
                up_ready !== (exp_q.size() < 2) || occupancy !== 2'(exp_q.size()) ||
                scratch_o !== m_scratch) begin
                n_fail++;
                $display("FAIL random%0d: got v=%b d=%h rdy=%b occ=%0d s=%h expected v=%b d=%h rdy=%b occ=%0d s=%h",
                         c, dn_valid, dn_data, up_ready, occupancy, scratch_o,
                         exp_q.size() > 0, exp_dn_data(), exp_q.size() < 2, exp_q.size(), m_scratch);
            end
        end
        flush = 1'b0; up_hold = 1'b0; up_valid = 1'b0;
    endtask

`ifdef PIPE_SKID_STATS_EN
    task automatic test_stats();
        bit acc;
        dn_ready = 1'b0; up_valid = 1'b1; up_data = rand_data();
        for (int c = 0; c < 70000; c++) tick(acc);
        n_cmp++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stall_sat: got %h expected ffff", stall_cnt); end
        tick(acc);
        tick(acc);
        n_cmp++; if (stall_cnt !== 16'(m_stall)) begin n_fail++; $display("FAIL stall_stays: got %h expected %h", stall_cnt, 16'(m_stall)); end
        n_cmp++; if (bubble_cnt !== 16'(m_bubble)) begin n_fail++; $display("FAIL bubble_cnt: got %h expected %h", bubble_cnt, 16'(m_bubble)); end
        up_valid = 1'b0;
    endtask
`endif

    initial begin
        m_scratch = '0;
        m_stall   = 0;
        m_bubble  = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_scratch();
        test_random();
`ifdef PIPE_SKID_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
